// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline hazard/sequencing controller:
// FSM state encoding, the NOP word loaded by flushes, and default limits.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } ctrl_state_e;

  // sll $0,$0,0 -- the all-zero word the flushed pipeline registers hold
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int MEM_WAIT_MAX_DEFAULT = 15;
  localparam int WAIT_CNT_W           = 8;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with synchronous active-high reset and increment enable.
module hazard_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of process ordering.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: branch
// redirect, load-use stall, data-memory wait freeze with timeout, perf counters.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEFAULT,
  parameter int CNT_W        = 32
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             Beq_MEM,
  input  logic             Bne_MEM,
  input  logic             ZeroFlag_MEM,
  input  logic [31:0]      PC_MEM,
  input  logic             MemRead_EX,
  input  logic [4:0]       WriteBackRegAddr_EX,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             MemReq,
  input  logic             MemReady,
  output logic             PCWriteEN,
  output logic             IFIDWriteEN,
  output logic             EXMEMWriteEN,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             EXMEMFlush,
  output logic             MEMWBBubble,
  output logic             PCSrcSEL,
  output logic [31:0]      PCBranch,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic             MemTimeout
);

  ctrl_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    timeout_q;
  logic                    taken, load_use;
  logic                    freeze, decode;

  assign taken    = (Beq_MEM & ZeroFlag_MEM) | (Bne_MEM & ~ZeroFlag_MEM);
  assign load_use = MemRead_EX && (WriteBackRegAddr_EX != 5'd0) &&
                    ((WriteBackRegAddr_EX == Rs_ID) || (WriteBackRegAddr_EX == Rt_ID));
  assign PCBranch = PC_MEM;

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    freeze     = 1'b0;
    decode     = 1'b0;
    case (state_q)
      RUN: begin
        if (MemReq && !MemReady) begin
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_CNT_W'(1);
        end else begin
          decode = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Completion releases the freeze in the same cycle; a branch held in
        // the frozen EX/MEM register is resolved right here.
        if (MemReady) begin
          decode     = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
          if (wait_cnt_q == WAIT_CNT_W'(MEM_WAIT_MAX)) begin
            state_d = HALT;
          end
        end
      end
      HALT: begin
        freeze = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_comb begin
    PCWriteEN    = 1'b1;
    IFIDWriteEN  = 1'b1;
    EXMEMWriteEN = 1'b1;
    IFIDFlush    = 1'b0;
    IDEXFlush    = 1'b0;
    EXMEMFlush   = 1'b0;
    MEMWBBubble  = 1'b0;
    PCSrcSEL     = 1'b0;
    if (freeze) begin
      PCWriteEN    = 1'b0;
      IFIDWriteEN  = 1'b0;
      EXMEMWriteEN = 1'b0;
      MEMWBBubble  = 1'b1;
    end else if (decode && taken) begin
      PCSrcSEL   = 1'b1;
      IFIDFlush  = 1'b1;
      IDEXFlush  = 1'b1;
      EXMEMFlush = 1'b1;
    end else if (decode && load_use) begin
      PCWriteEN   = 1'b0;
      IFIDWriteEN = 1'b0;
      IDEXFlush   = 1'b1;
    end
    // Reset drains the whole pipeline with NOPs regardless of state.
    if (RESET) begin
      PCWriteEN    = 1'b0;
      IFIDWriteEN  = 1'b0;
      EXMEMWriteEN = 1'b0;
      IFIDFlush    = 1'b1;
      IDEXFlush    = 1'b1;
      EXMEMFlush   = 1'b1;
      MEMWBBubble  = 1'b1;
      PCSrcSEL     = 1'b0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_q | (state_d == HALT);
    end
  end

  assign MemTimeout = timeout_q;

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .inc   (!PCWriteEN),
    .count (StallCount)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .inc   (PCSrcSEL),
    .count (FlushCount)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random
// traffic, compared every cycle against a behavioural model of the pipeline rules.
module tb_pipeline_hazard_ctrl;

  localparam int WAIT_MAX = 4;
  localparam int CW       = 8;
  localparam int SAT      = (1 << CW) - 1;

  logic          CLOCK;
  logic          RESET;
  logic          Beq_MEM, Bne_MEM, ZeroFlag_MEM;
  logic [31:0]   PC_MEM;
  logic          MemRead_EX;
  logic [4:0]    WriteBackRegAddr_EX, Rs_ID, Rt_ID;
  logic          MemReq, MemReady;
  logic          PCWriteEN, IFIDWriteEN, EXMEMWriteEN;
  logic          IFIDFlush, IDEXFlush, EXMEMFlush, MEMWBBubble, PCSrcSEL;
  logic [31:0]   PCBranch;
  logic [CW-1:0] StallCount, FlushCount;
  logic          MemTimeout;

  int errors = 0;
  int checks = 0;

  // Model state: consecutive not-ready cycles of the current access, halt flag,
  // saturating counter values, and whether a reset edge has been seen yet.
  int m_pending = 0;
  bit m_halted  = 1'b0;
  int m_stall   = 0;
  int m_flush   = 0;
  bit m_known   = 1'b0;

  pipeline_hazard_ctrl #(.MEM_WAIT_MAX(WAIT_MAX), .CNT_W(CW)) dut (
    .CLOCK               (CLOCK),
    .RESET               (RESET),
    .Beq_MEM             (Beq_MEM),
    .Bne_MEM             (Bne_MEM),
    .ZeroFlag_MEM        (ZeroFlag_MEM),
    .PC_MEM              (PC_MEM),
    .MemRead_EX          (MemRead_EX),
    .WriteBackRegAddr_EX (WriteBackRegAddr_EX),
    .Rs_ID               (Rs_ID),
    .Rt_ID               (Rt_ID),
    .MemReq              (MemReq),
    .MemReady            (MemReady),
    .PCWriteEN           (PCWriteEN),
    .IFIDWriteEN         (IFIDWriteEN),
    .EXMEMWriteEN        (EXMEMWriteEN),
    .IFIDFlush           (IFIDFlush),
    .IDEXFlush           (IDEXFlush),
    .EXMEMFlush          (EXMEMFlush),
    .MEMWBBubble         (MEMWBBubble),
    .PCSrcSEL            (PCSrcSEL),
    .PCBranch            (PCBranch),
    .StallCount          (StallCount),
    .FlushCount          (FlushCount),
    .MemTimeout          (MemTimeout)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control bits packed as {PCWE, IFIDWE, EXMEMWE, IFIDFl, IDEXFl, EXMEMFl, Bubble, PCSrc}.
  function automatic logic [7:0] model_ctrl();
    bit br, lu, frz;
    br  = (Beq_MEM && ZeroFlag_MEM) || (Bne_MEM && !ZeroFlag_MEM);
    lu  = MemRead_EX && (WriteBackRegAddr_EX != 0) &&
          (WriteBackRegAddr_EX == Rs_ID || WriteBackRegAddr_EX == Rt_ID);
    frz = m_halted || (((m_pending > 0) || MemReq) && !MemReady);
    if (RESET)    return 8'b0001_1110;
    if (frz)      return 8'b0000_0010;
    if (br)       return 8'b1111_1101;
    if (lu)       return 8'b0010_1000;
    return 8'b1110_0000;
  endfunction

  task automatic model_update(input logic [7:0] c);
    if (RESET) begin
      m_pending = 0;
      m_halted  = 1'b0;
      m_stall   = 0;
      m_flush   = 0;
      m_known   = 1'b1;
    end else begin
      if (!c[7] && m_stall < SAT) m_stall++;
      if (c[0] && m_flush < SAT)  m_flush++;
      if (!m_halted) begin
        if (c[1]) begin
          m_pending++;
          if (m_pending == WAIT_MAX + 1) m_halted = 1'b1;
        end else begin
          m_pending = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    logic [7:0] exp_c;
    @(negedge CLOCK);
    exp_c = model_ctrl();
    check("ctrl", {PCWriteEN, IFIDWriteEN, EXMEMWriteEN, IFIDFlush, IDEXFlush,
                   EXMEMFlush, MEMWBBubble, PCSrcSEL}, exp_c);
    check("pcbranch", PCBranch, PC_MEM);
    if (m_known) begin
      check("stall_cnt", StallCount, m_stall);
      check("flush_cnt", FlushCount, m_flush);
      check("timeout", MemTimeout, m_halted);
    end
    @(posedge CLOCK);
    model_update(exp_c);
    #1;
  endtask

  task automatic idle();
    Beq_MEM = 0; Bne_MEM = 0; ZeroFlag_MEM = 0; PC_MEM = 32'h0;
    MemRead_EX = 0; WriteBackRegAddr_EX = 0; Rs_ID = 0; Rt_ID = 0;
    MemReq = 0; MemReady = 0;
  endtask

  initial begin
    RESET = 1'b1;
    idle();

    // Reset held two cycles, then released.
    cycle();
    cycle();
    RESET = 1'b0;
    #1;
    check("post_reset_pcwe", PCWriteEN, 1);
    check("post_reset_stall", StallCount, 0);
    check("post_reset_flush", FlushCount, 0);
    cycle();

    // Taken BEQ to 0x40, then BNE with zero set (not taken).
    Beq_MEM = 1; ZeroFlag_MEM = 1; PC_MEM = 32'h0000_0040;
    cycle();
    idle();
    check("beq_flush_cnt", FlushCount, 1);
    Bne_MEM = 1; ZeroFlag_MEM = 1; PC_MEM = 32'h0000_0080;
    #1;
    check("bne_no_redirect", PCSrcSEL, 0);
    cycle();
    idle();

    // Load-use on Rt, then same pattern with $0 destination.
    MemRead_EX = 1; WriteBackRegAddr_EX = 5'd8; Rt_ID = 5'd8;
    cycle();
    idle();
    check("loaduse_stall_cnt", StallCount, 1);
    MemRead_EX = 1; WriteBackRegAddr_EX = 5'd0; Rt_ID = 5'd0;
    cycle();
    idle();
    check("loaduse_r0_stall_cnt", StallCount, 1);

    // Memory access with three wait cycles, then a same-cycle access.
    MemReq = 1; MemReady = 0;
    repeat (3) cycle();
    MemReady = 1;
    #1;
    check("mem_release_pcwe", PCWriteEN, 1);
    cycle();
    cycle();
    idle();
    check("mem_wait_stall_cnt", StallCount, 4);

    // Branch pending in EX/MEM while memory waits: resolved on release.
    MemReq = 1; MemReady = 0; Beq_MEM = 1; ZeroFlag_MEM = 1; PC_MEM = 32'h0000_1000;
    cycle();
    MemReady = 1;
    cycle();
    idle();

    // Memory never ready: timeout into HALT; long enough to saturate StallCount.
    MemReq = 1; MemReady = 0;
    repeat (270) cycle();
    check("halt_timeout", MemTimeout, 1);
    check("halt_stall_sat", StallCount, SAT);
    RESET = 1'b1;
    cycle();
    RESET = 1'b0;
    idle();
    check("halt_reset_timeout", MemTimeout, 0);
    check("halt_reset_stall", StallCount, 0);
    cycle();

    // Taken branch and load-use together: flush only, PC not held.
    Beq_MEM = 1; ZeroFlag_MEM = 1; PC_MEM = 32'h0000_0200;
    MemRead_EX = 1; WriteBackRegAddr_EX = 5'd5; Rs_ID = 5'd5;
    #1;
    check("br_lu_pcwe", PCWriteEN, 1);
    cycle();

    // Continuous taken branches saturate FlushCount.
    MemRead_EX = 0;
    repeat (260) cycle();
    check("flush_sat", FlushCount, SAT);
    idle();

    // Randomized traffic; reset is used to recover from HALT.
    for (int i = 0; i < 600; i++) begin
      RESET               = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      Beq_MEM             = ($urandom_range(0, 4) == 0);
      Bne_MEM             = ($urandom_range(0, 4) == 0);
      ZeroFlag_MEM        = 1'($urandom_range(0, 1));
      PC_MEM              = $urandom;
      MemRead_EX          = 1'($urandom_range(0, 1));
      WriteBackRegAddr_EX = 5'($urandom_range(0, 3));
      Rs_ID               = 5'($urandom_range(0, 3));
      Rt_ID               = 5'($urandom_range(0, 3));
      MemReq              = (m_pending > 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
      MemReady            = 1'($urandom_range(0, 1));
      cycle();
    end

    RESET = 1'b1;
    idle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
